// File: rtl/haze_frame_streamer.sv
// Streams a frame twice from frame memory onto AXI4-Stream: pass 1 with the core disabled,
// then (after ALE completes and a fixed gap) pass 2 with the core enabled.
module haze_frame_streamer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int ADDR_W     = 18,
  parameter int GAP_CYCLES = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic              ale_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [23:0]       mem_rdata,
  output logic [31:0]       M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY,
  output logic              enable,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] N_PIX     = (ADDR_W+1)'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [ADDR_W:0] LAST_ADDR = N_PIX - (ADDR_W+1)'(1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PASS1, WAIT_ALE, GAP, PASS2, DONE} state_t;

  state_t          state;
  logic [15:0]     gap_cnt;
  logic [ADDR_W:0] rd_cnt;        // one bit wider so it can reach N without wrapping
  logic            rd_pend;
  logic            rd_pend_last;

  // Prefetch FIFO entries carry {last, rgb}; the output register sits behind it.
  logic [24:0]     fifo_mem [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      fifo_cnt;
  logic [23:0]     out_data;
  logic            out_valid;
  logic            out_last;

  logic            in_pass;
  logic            xfer;
  logic            out_free;
  logic            pop;
  logic            push;
  logic [1:0]      occupancy;

  assign in_pass   = (state == PASS1) || (state == PASS2);
  assign occupancy = fifo_cnt + {1'b0, rd_pend};
  assign mem_rd    = in_pass && (rd_cnt < N_PIX) && (occupancy < 2'd2);
  assign mem_addr  = rd_cnt[ADDR_W-1:0];

  assign xfer      = out_valid && M_AXIS_TREADY;
  assign out_free  = !out_valid || M_AXIS_TREADY;
  assign pop       = out_free && (fifo_cnt != 2'd0);
  // Returning data bypasses the FIFO when it is empty and the output can take it.
  assign push      = rd_pend && !(out_free && (fifo_cnt == 2'd0));

  assign M_AXIS_TDATA  = {8'h00, out_data};
  assign M_AXIS_TVALID = out_valid;
  assign M_AXIS_TLAST  = out_last;

  // NOTE: storage arrays are not reset; fifo_cnt alone decides which entries are valid.
  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wr_ptr] <= {rd_pend_last, mem_rdata};
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      rd_cnt       <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_cnt     <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      enable       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (mem_rd)       rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
      else if (!in_pass) rd_cnt <= '0;
      rd_pend      <= mem_rd;
      rd_pend_last <= mem_rd && (rd_cnt == LAST_ADDR);

      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

      if (out_free) begin
        if (pop) begin
          {out_last, out_data} <= fifo_mem[rd_ptr];
          out_valid            <= 1'b1;
        end else if (rd_pend) begin
          out_data  <= mem_rdata;
          out_last  <= rd_pend_last;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= PASS1;
            busy  <= 1'b1;
          end
        end
        PASS1: begin
          if (xfer && out_last) state <= WAIT_ALE;
        end
        WAIT_ALE: begin
          if (ale_done) begin
            state   <= GAP;
            enable  <= 1'b1;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (gap_cnt == GAP_LAST) state <= PASS2;
        end
        PASS2: begin
          if (xfer && out_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
